// File: rtl/vehicle_powertrain.sv
// vehicle_powertrain: speed physics, automatic gearbox FSM, cruise control and registered RPM
module vehicle_powertrain #(
  parameter int SPEED_W     = 8,
  parameter int MAX_SPEED   = 250,
  parameter int REV_MAX     = 50,
  parameter int DEADZONE    = 5,
  parameter int NUM_GEARS   = 6,
  parameter int GEAR_BAND   = 40,
  parameter int DOWN_HYST   = 5,
  parameter int SHIFT_TICKS = 4,
  parameter int IDLE_RPM    = 800,
  parameter int RPM_SLOPE   = 50,
  parameter int RPM_MAX     = 8000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               engine_on,
  input  logic               tick_speed,
  input  logic [3:0]         current_gear,
  input  logic [7:0]         adc_accel,
  input  logic               is_brake_normal,
  input  logic               is_brake_hard,
  input  logic               cruise_set,
  input  logic               cruise_cancel,
  output logic [SPEED_W-1:0] speed,
  output logic [2:0]         drive_gear,
  output logic [13:0]        rpm,
  output logic               shifting,
  output logic               cruise_active,
  output logic [SPEED_W-1:0] cruise_target,
  output logic               ess_trigger
);
  typedef enum logic [1:0] {NEUTRAL, REVERSE, DRIVE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d, target_q, target_d;
  logic [2:0] gear_q, gear_d;
  logic [13:0] rpm_q, rpm_d;
  logic [7:0] cnt_q, cnt_d, eff, power;
  logic cruise_q, cruise_d, ess_q, ess_d, up_q, up_d, sel_drv, sel_rev, fwd, cancel, last_tick;
  int spd, res, lim, nxt, dec, diff, r;
  assign sel_drv = current_gear == 4'd12;
  assign sel_rev = current_gear == 4'd6;
  assign fwd = state_q == DRIVE || state_q == SHIFT;
  assign eff = adc_accel > 8'(DEADZONE) ? adc_accel - 8'(DEADZONE) : 8'd0;
  assign power = fwd ? eff : state_q == REVERSE ? eff >> 1 : 8'd0;
  assign spd = int'(speed_q);
  assign res = spd + 5;
  assign cancel = is_brake_normal | is_brake_hard | cruise_cancel | ~sel_drv | ~engine_on;
  assign last_tick = cnt_q == 8'(SHIFT_TICKS - 1);
  always_comb begin
    lim = state_q == REVERSE ? REV_MAX : MAX_SPEED;
    dec = is_brake_hard ? (spd > 150 ? 2 : spd > 80 ? 4 : 8) : (spd > 150 ? 1 : spd > 80 ? 2 : 3);
    nxt = spd;
    if (is_brake_hard || is_brake_normal) nxt = spd > dec ? spd - dec : 0;
    else if (state_q == SHIFT) nxt = spd;
    else if (int'(power) > res) nxt = spd + 1 > lim ? spd : spd + 1;
    else if (cruise_q) nxt = spd < int'(target_q) ? spd + 1 : spd > int'(target_q) ? spd - 1 : spd;
    else if (int'(power) < res) nxt = spd > 0 ? spd - 1 : 0;
    speed_d = !engine_on ? '0 : tick_speed ? SPEED_W'(nxt) : speed_q;
    ess_d = !engine_on ? 1'b0 : tick_speed ? is_brake_hard && spd > 50 : ess_q;
    cruise_d = cancel ? 1'b0 : cruise_set && spd >= 30 ? 1'b1 : cruise_q;
    target_d = !cancel && cruise_set && spd >= 30 ? speed_q : target_q;
  end
  always_comb begin
    state_d = state_q;
    gear_d = gear_q;
    cnt_d = cnt_q;
    up_d = up_q;
    if (!engine_on) begin
      state_d = NEUTRAL;
      gear_d = '0;
      cnt_d = '0;
    end else if (fwd && !sel_drv) begin
      state_d = sel_rev ? REVERSE : NEUTRAL;
      gear_d = {2'b0, sel_rev};
      cnt_d = '0;
    end else if (state_q == NEUTRAL) begin
      state_d = sel_drv ? DRIVE : sel_rev ? REVERSE : NEUTRAL;
      gear_d = {2'b0, sel_drv | sel_rev};
    end else if (state_q == REVERSE) begin
      state_d = sel_rev ? REVERSE : NEUTRAL;
      gear_d = {2'b0, sel_rev};
    end else if (state_q == DRIVE) begin
      up_d = int'(gear_q) < NUM_GEARS && spd >= int'(gear_q) * GEAR_BAND;
      state_d = up_d || (gear_q > 3'd1 && spd < (int'(gear_q) - 1) * GEAR_BAND - DOWN_HYST) ? SHIFT : DRIVE;
      cnt_d = '0;
    end else if (tick_speed) begin
      cnt_d = last_tick ? 8'd0 : cnt_q + 8'd1;
      state_d = last_tick ? DRIVE : SHIFT;
      gear_d = !last_tick ? gear_q : up_q ? gear_q + 3'd1 : gear_q - 3'd1;
    end
  end
  always_comb begin
    diff = spd - (int'(gear_q) - 1) * GEAR_BAND;
    r = state_q == NEUTRAL ? IDLE_RPM + int'(eff) * 20 : IDLE_RPM + (diff > 0 ? diff : 0) * RPM_SLOPE;
    rpm_d = engine_on ? 14'(r > RPM_MAX ? RPM_MAX : r) : 14'd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= NEUTRAL;
      speed_q <= '0;
      target_q <= '0;
      gear_q <= '0;
      rpm_q <= '0;
      cnt_q <= '0;
      cruise_q <= 1'b0;
      ess_q <= 1'b0;
      up_q <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      target_q <= target_d;
      gear_q <= gear_d;
      rpm_q <= rpm_d;
      cnt_q <= cnt_d;
      cruise_q <= cruise_d;
      ess_q <= ess_d;
      up_q <= up_d;
    end
  assign speed = speed_q;
  assign drive_gear = gear_q;
  assign rpm = rpm_q;
  assign shifting = state_q == SHIFT;
  assign cruise_active = cruise_q;
  assign cruise_target = target_q;
  assign ess_trigger = ess_q;
endmodule
